// File: rtl/ot_pkg.sv
// rtl/ot_pkg.sv - shared state encodings, error codes and byte-count helper for the OT receiver
package ot_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_RX_N, S_RX_E, S_RX_X, S_RAND, S_EXP,
    S_ADD, S_TX_V, S_RX_M, S_UNPACK, S_DONE, S_ERROR
  } ot_state_e;

  typedef enum logic [1:0] {ME_IDLE, ME_SQR, ME_MUL, ME_DONE} me_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SEL     = 2'd1,
    ERR_N_SMALL = 2'd2
  } ot_err_e;

  function automatic int key_bytes(input int key_w);
    return key_w / 8;
  endfunction

endpackage

// File: rtl/ot_modexp.sv
// rtl/ot_modexp.sv - left-to-right square-and-multiply over a bit-serial shift-add modular multiplier
module ot_modexp
  import ot_pkg::*;
#(
  parameter int KEY_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [KEY_W-1:0] base_i,
  input  logic [KEY_W-1:0] exp_i,
  input  logic [KEY_W-1:0] mod_i,
  output logic             done_o,
  output logic [KEY_W-1:0] result_o
);

  localparam int CW = $clog2(KEY_W);

  me_state_e        state_q, state_d;
  logic [KEY_W-1:0] res_q, res_d, acc_q, acc_d, mpl_q, mpl_d;
  logic [CW-1:0]    bit_q, bit_d, cnt_q, cnt_d;
  logic [KEY_W-1:0] addend;
  logic [KEY_W:0]   modx, dbl, dbl_red, sum, sum_red;
  logic             last_step;

  // Operands stay below mod_i, so one correction after doubling and one after adding suffice.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    acc_d     = acc_q;
    mpl_d     = mpl_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    done_o    = 1'b0;
    modx      = {1'b0, mod_i};
    dbl       = {acc_q, 1'b0};
    dbl_red   = (dbl >= modx) ? dbl - modx : dbl;
    addend    = (state_q == ME_MUL) ? base_i : res_q;
    sum       = dbl_red + (mpl_q[KEY_W-1] ? {1'b0, addend} : '0);
    sum_red   = (sum >= modx) ? sum - modx : sum;
    last_step = (cnt_q == CW'(KEY_W - 1));
    case (state_q)
      ME_IDLE: begin
        if (start_i) begin
          res_d   = KEY_W'(1);
          acc_d   = '0;
          mpl_d   = KEY_W'(1);
          bit_d   = CW'(KEY_W - 1);
          cnt_d   = '0;
          state_d = ME_SQR;
        end
      end
      ME_SQR, ME_MUL: begin
        acc_d = KEY_W'(sum_red);
        mpl_d = mpl_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          res_d = KEY_W'(sum_red);
          acc_d = '0;
          mpl_d = KEY_W'(sum_red);
          cnt_d = '0;
          if (state_q == ME_SQR && exp_i[bit_q]) begin
            state_d = ME_MUL;
          end else if (bit_q == '0) begin
            state_d = ME_DONE;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = ME_SQR;
          end
        end
      end
      ME_DONE: begin
        done_o  = 1'b1;
        state_d = ME_IDLE;
      end
      default: state_d = ME_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ME_IDLE;
      res_q   <= '0;
      acc_q   <= '0;
      mpl_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      mpl_q   <= mpl_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/ot_receiver_mn.sv
// rtl/ot_receiver_mn.sv - 1-of-NMSG oblivious transfer receiver: byte-stream protocol controller
module ot_receiver_mn
  import ot_pkg::*;
#(
  parameter int KEY_W = 32,
  parameter int NMSG  = 2,
  parameter int SEL_W = $clog2(NMSG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [7:0]       rx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             rand_req,
  input  logic             rand_valid,
  input  logic [KEY_W-1:0] rand_data,
  output logic [KEY_W-1:0] unpack_res,
  output logic             res_valid,
  output logic             busy,
  output logic             err
);

  localparam int NB = key_bytes(KEY_W);
  localparam int BW = $clog2(NB) + 1;

  ot_state_e        state_q, state_d;
  ot_err_e          err_q, err_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [3:0]       msg_q, msg_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [KEY_W-9:0] sh_q, sh_d;
  logic [KEY_W-1:0] n_q, n_d, e_q, e_d, x_q, x_d, k_q, k_d;
  logic [KEY_W-1:0] v_q, v_d, m_q, m_d, res_q, res_d;
  logic [KEY_W-1:0] fld, me_res;
  logic [KEY_W:0]   add_sum, sub_diff;
  logic             rx_fire, tx_fire, last_byte, msg_is_sel, msg_last, me_start, me_done;

  assign rx_ready   = (state_q == S_RX_N) || (state_q == S_RX_E) ||
                      (state_q == S_RX_X) || (state_q == S_RX_M);
  assign tx_valid   = (state_q == S_TX_V);
  assign tx_data    = v_q[KEY_W-1 -: 8];
  assign rand_req   = (state_q == S_RAND);
  assign res_valid  = (state_q == S_DONE);
  assign unpack_res = res_q;
  assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign err        = (err_q != ERR_NONE);

  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign fld        = {sh_q, rx_data};
  assign last_byte  = (byte_q == BW'(NB - 1));
  assign msg_is_sel = (32'(msg_q) == 32'(sel_q));
  assign msg_last   = (msg_q == 4'(NMSG - 1));
  assign add_sum    = {1'b0, x_q} + {1'b0, me_res};
  assign sub_diff   = {1'b0, m_q} - {1'b0, k_q};

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    byte_d   = byte_q;
    msg_d    = msg_q;
    sel_d    = sel_q;
    sh_d     = sh_q;
    n_d      = n_q;
    e_d      = e_q;
    x_d      = x_q;
    k_d      = k_q;
    v_d      = v_q;
    m_d      = m_q;
    res_d    = res_q;
    me_start = 1'b0;
    if (rx_fire) begin
      sh_d   = fld[KEY_W-9:0];
      byte_d = last_byte ? '0 : byte_q + 1'b1;
    end
    if (tx_fire) begin
      v_d    = v_q << 8;
      byte_d = last_byte ? '0 : byte_q + 1'b1;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sel_d  = sel;
          byte_d = '0;
          msg_d  = '0;
          if (32'(sel) >= NMSG) begin
            err_d   = ERR_SEL;
            state_d = S_ERROR;
          end else begin
            state_d = S_RX_N;
          end
        end
      end
      S_RX_N: if (rx_fire && last_byte) begin
        n_d = fld;
        if (fld < KEY_W'(2)) begin
          err_d   = ERR_N_SMALL;
          state_d = S_ERROR;
        end else begin
          state_d = S_RX_E;
        end
      end
      S_RX_E: if (rx_fire && last_byte) begin
        e_d     = fld;
        state_d = S_RX_X;
      end
      S_RX_X, S_RX_M: if (rx_fire && last_byte) begin
        if (msg_is_sel && state_q == S_RX_X) x_d = fld;
        if (msg_is_sel && state_q == S_RX_M) m_d = fld;
        if (msg_last) begin
          msg_d   = '0;
          state_d = (state_q == S_RX_X) ? S_RAND : S_UNPACK;
        end else begin
          msg_d = msg_q + 1'b1;
        end
      end
      // The modexp engine reads the base only in its multiply phase, after k_q has loaded.
      S_RAND: if (rand_valid && rand_data != '0 && rand_data < n_q) begin
        k_d      = rand_data;
        me_start = 1'b1;
        state_d  = S_EXP;
      end
      S_EXP: if (me_done) state_d = S_ADD;
      S_ADD: begin
        v_d     = (add_sum >= {1'b0, n_q}) ? KEY_W'(add_sum - {1'b0, n_q}) : KEY_W'(add_sum);
        byte_d  = '0;
        state_d = S_TX_V;
      end
      S_TX_V: if (tx_fire && last_byte) state_d = S_RX_M;
      S_UNPACK: begin
        res_d   = sub_diff[KEY_W] ? sub_diff[KEY_W-1:0] + n_q : sub_diff[KEY_W-1:0];
        state_d = S_DONE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      byte_q  <= '0;
      msg_q   <= '0;
      sel_q   <= '0;
      sh_q    <= '0;
      n_q     <= '0;
      e_q     <= '0;
      x_q     <= '0;
      k_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      byte_q  <= byte_d;
      msg_q   <= msg_d;
      sel_q   <= sel_d;
      sh_q    <= sh_d;
      n_q     <= n_d;
      e_q     <= e_d;
      x_q     <= x_d;
      k_q     <= k_d;
      v_q     <= v_d;
      m_q     <= m_d;
      res_q   <= res_d;
    end
  end

  ot_modexp #(.KEY_W(KEY_W)) u_modexp (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (me_start),
    .base_i   (k_q),
    .exp_i    (e_q),
    .mod_i    (n_q),
    .done_o   (me_done),
    .result_o (me_res)
  );

endmodule

// File: tb/tb_ot_receiver_mn.sv
// tb/tb_ot_receiver_mn.sv - randomized self-checking bench for ot_receiver_mn against an arithmetic model
module tb_ot_receiver_mn;

  localparam int KW = 32;
  localparam int NM = 4;
  localparam int SW = 3;
  localparam int NB = KW / 8;
  localparam int EXP_BOUND = 2 * KW * (KW + 2) + 2;

  logic          clk = 1'b0;
  logic          reset, start, rx_valid, tx_ready, rand_valid;
  logic [SW-1:0] sel;
  logic [7:0]    rx_data;
  logic [KW-1:0] rand_data;
  logic          rx_ready, tx_valid, rand_req, res_valid, busy, err;
  logic [7:0]    tx_data;
  logic [KW-1:0] unpack_res;

  ot_receiver_mn #(.KEY_W(KW), .NMSG(NM), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rand_req(rand_req), .rand_valid(rand_valid), .rand_data(rand_data),
    .unpack_res(unpack_res), .res_valid(res_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    exp_tx[$];
  logic [KW-1:0] exp_res;
  bit            res_armed = 1'b0;
  int            tx_count = 0;
  int            rand_hs = 0;
  int            stall_at = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic longint unsigned modpow(input longint unsigned b, input longint unsigned e,
                                             input longint unsigned n);
    longint unsigned r = 1;
    for (int i = KW - 1; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * b) % n;
    end
    return r;
  endfunction

  function automatic logic [KW-1:0] model_v(input longint unsigned x, input longint unsigned ke,
                                            input longint unsigned n);
    longint unsigned s = x + ke;
    if (s >= n) s = s - n;
    return KW'(s);
  endfunction

  function automatic logic [KW-1:0] model_r(input longint unsigned m, input longint unsigned k,
                                            input longint unsigned n);
    if (m >= k) return KW'(m - k);
    return KW'(m + n - k);
  endfunction

  // Single compare process: streams, holds, handshake counts and result, sampled mid-cycle.
  initial begin
    bit         pend;
    logic [7:0] pdata;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        check("tx_hold_valid", 64'(tx_valid), 64'd1);
        check("tx_hold_data", 64'(tx_data), 64'(pdata));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra_byte actual=%0d required=none", tx_data);
        end else begin
          check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
        end
        tx_count++;
      end
      pend  = tx_valid && !tx_ready;
      pdata = tx_data;
      if (rand_req && rand_valid) rand_hs++;
      if (res_valid && res_armed) check("unpack_res", 64'(unpack_res), 64'(exp_res));
      if (tx_valid || rand_req) check("rx_ready_quiet", 64'(rx_ready), 64'd0);
      if (err) check("err_quiet", 64'({busy, rx_ready, tx_valid, rand_req}), 64'd0);
    end
  end

  initial begin
    int stalled;
    stalled  = -1;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at < 0) stalled = -1;
      if (stall_at >= 0 && tx_count == stall_at && stalled < 0) stalled = 10;
      if (stalled > 0) begin
        tx_ready = 1'b0;
        stalled--;
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #900000;
    timeout_fail("global_watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit hs;
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      hs = rx_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 5000) timeout_fail("rx_ready_wait");
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic send_field(input logic [KW-1:0] v);
    for (int i = NB - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic serve_rand(input logic [KW-1:0] v);
    int n = 0;
    forever begin
      @(negedge clk);
      if (rand_req) break;
      n++;
      if (n > 1000) timeout_fail("rand_req_wait");
    end
    @(posedge clk);
    #1;
    rand_valid = 1'b1;
    rand_data  = v;
    tick();
    rand_valid = 1'b0;
    rand_data  = KW'($urandom);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    start      = 1'b0;
    rx_valid   = 1'b0;
    rand_valid = 1'b0;
    tick();
    check("reset_outs", 64'({rx_ready, tx_valid, rand_req, res_valid, busy, err, tx_data, unpack_res}), 64'd0);
    reset     = 1'b0;
    res_armed = 1'b0;
    stall_at  = -1;
    exp_tx.delete();
  endtask

  task automatic pulse_start(input logic [SW-1:0] s);
    start = 1'b1;
    sel   = s;
    tick();
    start = 1'b0;
    sel   = SW'($urandom);
  endtask

  // abort: 0 = full session, 1 = reset mid-EXP, 2 = reset mid-RX_M
  task automatic run_session(input logic [SW-1:0] s, input logic [KW-1:0] n, input logic [KW-1:0] e,
                             input logic [KW-1:0] xs[NM], input logic [KW-1:0] ks[$],
                             input logic [KW-1:0] ms[NM], input logic [KW-1:0] v,
                             input logic [KW-1:0] r, input int abort, input int stall);
    int h0;
    int cyc = 0;
    res_armed = 1'b0;
    h0        = rand_hs;
    for (int i = NB - 1; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
    stall_at = (stall >= 0) ? tx_count + stall : -1;
    pulse_start(s);
    exp_res   = r;
    res_armed = 1'b1;
    check("busy_after_start", 64'(busy), 64'd1);
    check("res_valid_cleared", 64'(res_valid), 64'd0);
    send_field(n);
    send_field(e);
    for (int i = 0; i < NM; i++) send_field(xs[i]);
    foreach (ks[i]) serve_rand(ks[i]);
    check("rand_handshakes", 64'(rand_hs - h0), 64'(ks.size()));
    if (abort == 1) begin
      repeat (50) tick();
      do_reset();
      return;
    end
    while (!tx_valid) begin
      tick();
      cyc++;
      if (cyc > EXP_BOUND + 10) timeout_fail("exp_latency_wait");
    end
    check("exp_latency_in_bound", 64'(cyc <= EXP_BOUND), 64'd1);
    if (abort == 2) begin
      send_byte(ms[0][KW-1 -: 8]);
      do_reset();
      return;
    end
    for (int i = 0; i < NM; i++) send_field(ms[i]);
    cyc = 0;
    while (!res_valid) begin
      tick();
      cyc++;
      if (cyc > 50) timeout_fail("res_valid_wait");
    end
    repeat (3) tick();
    check("busy_in_done", 64'(busy), 64'd0);
    check("res_valid_held", 64'(res_valid), 64'd1);
    check("tx_all_sent", 64'(exp_tx.size()), 64'd0);
    stall_at = -1;
  endtask

  initial begin
    logic [KW-1:0] xs[NM];
    logic [KW-1:0] ms[NM];
    logic [KW-1:0] ks[$];
    logic [KW-1:0] n, e, k, ke;
    int            sl;

    reset = 1'b1; start = 1'b0; sel = '0; rx_valid = 1'b0; rx_data = '0;
    rand_valid = 1'b0; rand_data = '0;
    repeat (2) tick();
    do_reset();

    check("model_modpow_5_17", 64'(modpow(5, 17, 3233)), 64'd3086);
    check("model_modpow_e0", 64'(modpow(1234, 0, 3233)), 64'd1);
    check("model_v_wrap", 64'(model_v(200, 3086, 3233)), 64'd53);
    check("model_v_boundary", 64'(model_v(3232, 1, 3233)), 64'd0);
    check("model_r_borrow", 64'(model_r(2, 5, 3233)), 64'd3230);

    xs = '{32'd100, 32'd200, 32'd300, 32'd400};
    ms = '{32'd7, 32'd1005, 32'd11, 32'd12};
    ks = '{32'd4000, 32'd0, 32'd5};
    run_session(3'd1, 32'd3233, 32'd17, xs, ks, ms, 32'h0000_0035, 32'd1000, 0, 2);

    ms = '{32'd2, 32'd1005, 32'd11, 32'd12};
    ks = '{32'd5};
    run_session(3'd0, 32'd3233, 32'd17, xs, ks, ms, 32'd3186, 32'd3230, 0, -1);

    xs = '{32'd1, 32'd2, 32'd3, 32'd3232};
    ks = '{32'd7};
    run_session(3'd3, 32'd3233, 32'd0, xs, ks, ms, 32'd0, 32'd0, 2, -1);

    for (int s = 0; s < 10; s++) begin
      n = ($urandom_range(0, 1) == 1) ? KW'($urandom_range(2, 5000)) : KW'($urandom);
      if (n < 2) n = 2;
      e = ($urandom_range(0, 3) == 0) ? '0 : KW'($urandom);
      for (int i = 0; i < NM; i++) begin
        xs[i] = KW'($urandom) % n;
        ms[i] = KW'($urandom);
      end
      ks = {};
      repeat ($urandom_range(0, 2)) begin
        case ($urandom_range(0, 2))
          0: ks.push_back('0);
          1: ks.push_back(n);
          default: ks.push_back(32'hFFFF_FFFF);
        endcase
      end
      k = 1 + (KW'($urandom) % (n - 1));
      ks.push_back(k);
      sl = $urandom_range(0, NM - 1);
      ke = KW'(modpow(k, e, n));
      run_session(SW'(sl), n, e, xs, ks, ms, model_v(xs[sl], ke, n),
                  model_r(ms[sl], k, n), (s == 4) ? 1 : 0, -1);
    end

    pulse_start(3'd5);
    check("sel_range_err", 64'(err), 64'd1);
    check("sel_range_busy", 64'(busy), 64'd0);
    do_reset();

    pulse_start(3'd0);
    send_field(32'd1);
    check("n_small_err", 64'(err), 64'd1);
    check("n_small_rx_ready", 64'(rx_ready), 64'd0);
    pulse_start(3'd0);
    tick();
    check("err_sticky", 64'(err), 64'd1);
    check("err_start_ignored", 64'({busy, rx_ready}), 64'd0);
    do_reset();
    check("err_cleared", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
